// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response channel shared by the fetch stage (master)
// and the instruction memory (slave).
interface instr_fetch_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req_87;
    logic [ADDR_W-1:0]  imem_addr_87;
    logic               imem_rdy_87;
    logic               imem_rsp_vld_87;
    logic [INSTR_W-1:0] imem_rsp_data_87;

    modport master (
        output imem_req_87,
        output imem_addr_87,
        input  imem_rdy_87,
        input  imem_rsp_vld_87,
        input  imem_rsp_data_87
    );

    modport slave (
        input  imem_req_87,
        input  imem_addr_87,
        output imem_rdy_87,
        output imem_rsp_vld_87,
        output imem_rsp_data_87
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers responses and drives IF/ID.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module instr_fetch #(
    parameter int                ADDR_W     = 32,
    parameter int                INSTR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk_87,
    input  logic               rst_87,
    instr_fetch_if.master      imem,
    input  logic               stall_87,
    input  logic               redirect_87,
    input  logic [ADDR_W-1:0]  redirect_pc_87,
    output logic [ADDR_W-1:0]  pc_out_87,
    output logic [INSTR_W-1:0] instr_out_87,
    output logic               instr_vld_87,
    output logic [31:0]        perf_fetched_87,
    output logic [31:0]        perf_stall_87
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // IDLE: one-cycle gap after reset, FETCH: issuing, FLUSH: dropping pre-redirect responses
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0]  r_pc, r_rsp_pc, r_pc_out;
    logic               r_req, r_vld;
    logic [INSTR_W-1:0] r_instr;
    logic [CW-1:0]      r_outst, r_discard, r_count;
    logic [PW-1:0]      r_wptr, r_rptr;
    logic [INSTR_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_fifo_pc   [FIFO_DEPTH];

    logic              w_acc, w_rsp, w_keep, w_pop_ok, w_pop, w_bypass, w_push, w_req_nxt;
    logic              w_load_vld, w_load_bub;
    logic [CW-1:0]     w_outst_nxt, w_discard_nxt, w_count_nxt;
    logic [CW:0]       w_credit;
    logic [ADDR_W-1:0] w_redir_pc;

    assign imem.imem_req_87  = r_req;
    assign imem.imem_addr_87 = r_pc;
    assign pc_out_87         = r_pc_out;
    assign instr_out_87      = r_instr;
    assign instr_vld_87      = r_vld;

    always_comb begin
        w_redir_pc = redirect_pc_87 & ~ADDR_W'(3);
        w_acc      = r_req & imem.imem_rdy_87;
        w_rsp      = imem.imem_rsp_vld_87;
        w_keep     = w_rsp & ~redirect_87 & (r_discard == '0);
        w_pop_ok   = ~stall_87 & ~redirect_87;
        w_pop      = w_pop_ok & (r_count != '0);
        w_bypass   = w_keep & w_pop_ok & (r_count == '0);
        w_push     = w_keep & ~w_bypass;
        w_load_vld = w_pop | w_bypass;
        w_load_bub = redirect_87 | (~stall_87 & ~w_load_vld);

        w_outst_nxt = r_outst + CW'(w_acc) - CW'(w_rsp);
        w_count_nxt = redirect_87 ? '0 : r_count + CW'(w_push) - CW'(w_pop);

        // A request accepted in the redirect cycle still returns data, so it is discarded too
        w_discard_nxt = r_discard;
        if (redirect_87)
            w_discard_nxt = w_outst_nxt;
        else if (w_rsp && (r_discard != '0))
            w_discard_nxt = r_discard - CW'(1);

        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   w_state_nxt = FETCH;
            FLUSH:   if (w_discard_nxt == '0) w_state_nxt = FETCH;
            default: w_state_nxt = IDLE;
        endcase
        if (redirect_87)
            w_state_nxt = (w_discard_nxt != '0) ? FLUSH : FETCH;

        w_credit  = {1'b0, w_outst_nxt} + {1'b0, w_count_nxt};
        w_req_nxt = (w_state_nxt == FETCH) && !redirect_87 && (w_credit < (CW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_rsp_pc  <= RESET_PC;
            r_req     <= 1'b0;
            r_outst   <= '0;
            r_discard <= '0;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_pc_out  <= '0;
            r_instr   <= '0;
            r_vld     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_outst   <= w_outst_nxt;
            r_discard <= w_discard_nxt;
            r_count   <= w_count_nxt;
            if (redirect_87) begin
                r_pc     <= w_redir_pc;
                r_rsp_pc <= w_redir_pc;
                r_wptr   <= '0;
                r_rptr   <= '0;
            end else begin
                if (w_acc)  r_pc     <= r_pc + ADDR_W'(4);
                if (w_keep) r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
                if (w_push) r_wptr   <= r_wptr + PW'(1);
                if (w_pop)  r_rptr   <= r_rptr + PW'(1);
            end
            if (w_load_bub) begin
                r_instr <= '0;
                r_vld   <= 1'b0;
            end else if (w_pop) begin
                r_instr  <= r_fifo_data[r_rptr];
                r_pc_out <= r_fifo_pc[r_rptr] + ADDR_W'(4);
                r_vld    <= 1'b1;
            end else if (w_bypass) begin
                r_instr  <= imem.imem_rsp_data_87;
                r_pc_out <= r_rsp_pc + ADDR_W'(4);
                r_vld    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_87) begin
        if (w_push && !rst_87) begin
            r_fifo_data[r_wptr] <= imem.imem_rsp_data_87;
            r_fifo_pc[r_wptr]   <= r_rsp_pc;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched, r_perf_stall;

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_load_vld && !w_load_bub && !stall_87 && (r_perf_fetched != '1))
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (!stall_87 && w_load_bub && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched_87 = r_perf_fetched;
    assign perf_stall_87   = r_perf_stall;
`else
    assign perf_fetched_87 = '0;
    assign perf_stall_87   = '0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural imem returning the address as data with
// programmable latency, plus a second instance that only exercises PC wrap-around.
module tb_instr_fetch;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 2;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc_out, instr_out, perf_f, perf_s;
    logic        instr_vld;
    logic [31:0] w_pc_out, w_instr_out, w_perf_f, w_perf_s;
    logic        w_instr_vld;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_ent_t;
    mem_ent_t mq[$];

    instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) imem_if ();
    instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) wrap_if ();

    instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk_87(clk), .rst_87(rst), .imem(imem_if),
        .stall_87(stall), .redirect_87(redirect), .redirect_pc_87(redirect_pc),
        .pc_out_87(pc_out), .instr_out_87(instr_out), .instr_vld_87(instr_vld),
        .perf_fetched_87(perf_f), .perf_stall_87(perf_s)
    );

    instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk_87(clk), .rst_87(rst), .imem(wrap_if),
        .stall_87(1'b0), .redirect_87(1'b0), .redirect_pc_87(32'h0),
        .pc_out_87(w_pc_out), .instr_out_87(w_instr_out), .instr_vld_87(w_instr_vld),
        .perf_fetched_87(w_perf_f), .perf_stall_87(w_perf_s)
    );

    assign wrap_if.imem_rdy_87      = 1'b1;
    assign wrap_if.imem_rsp_vld_87  = 1'b0;
    assign wrap_if.imem_rsp_data_87 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: acceptance seen mid-cycle at the falling edge, answered lat cycles later in order
    initial begin
        imem_if.imem_rsp_vld_87  = 1'b0;
        imem_if.imem_rsp_data_87 = '0;
        forever begin
            @(negedge clk);
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_if.imem_rsp_vld_87  = 1'b1;
                imem_if.imem_rsp_data_87 = mq[0].addr;
                mq.delete(0);
            end else begin
                imem_if.imem_rsp_vld_87  = 1'b0;
                imem_if.imem_rsp_data_87 = '0;
            end
            if (imem_if.imem_req_87 && imem_if.imem_rdy_87)
                mq.push_back('{imem_if.imem_addr_87, cyc + lat});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        imem_if.imem_rdy_87 = 1'b1;
        lat = 1;
        repeat (3) tick();
        checks++;
        if ({imem_if.imem_req_87, instr_vld, instr_out, pc_out} !== 66'h0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b vld=%b instr=%h pc=%h exp all 0",
                     imem_if.imem_req_87, instr_vld, instr_out, pc_out);
        end
        checks++;
        if ({perf_f, perf_s} !== 64'h0) begin
            errors++;
            $display("FAIL reset_perf got %h/%h exp 0/0", perf_f, perf_s);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_req got req=%b addr=%h vld=%b exp 1/00000000/0",
                     imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld);
        end
        tick();
        checks++;
        if ({imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld} !== {1'b1, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL second_req got req=%b addr=%h vld=%b exp 1/00000004/0",
                     imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld);
        end
        checks++;
        if (perf_s !== (PERF ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL idle_bubbles got %0d exp %0d", perf_s, PERF ? 2 : 0);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        for (int k = 0; k < 3; k++) begin
            tick();
            e = 32'(4 * k);
            checks++;
            if ({instr_vld, instr_out, pc_out} !== {1'b1, e, e + 32'd4}) begin
                errors++;
                $display("FAIL stream_%0d got vld=%b instr=%h pc=%h exp 1/%h/%h",
                         k, instr_vld, instr_out, pc_out, e, e + 32'd4);
            end
        end
        checks++;
        if (perf_f !== (PERF ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL stream_fetched got %0d exp %0d", perf_f, PERF ? 3 : 0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({instr_vld, instr_out, pc_out} !== {1'b1, 32'h8, 32'hC}) begin
                errors++;
                $display("FAIL stall_hold_%0d got vld=%b instr=%h pc=%h exp 1/00000008/0000000c",
                         k, instr_vld, instr_out, pc_out);
            end
            checks++;
            if (imem_if.imem_req_87 !== 1'b0) begin
                errors++;
                $display("FAIL stall_credit_%0d got req=%b exp 0", k, imem_if.imem_req_87);
            end
        end
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            e = 32'(12 + 4 * k);
            checks++;
            if ({instr_vld, instr_out, pc_out} !== {1'b1, e, e + 32'd4}) begin
                errors++;
                $display("FAIL stall_resume_%0d got vld=%b instr=%h pc=%h exp 1/%h/%h",
                         k, instr_vld, instr_out, pc_out, e, e + 32'd4);
            end
        end
        checks++;
        if ({perf_f, perf_s} !== (PERF ? {32'd6, 32'd2} : 64'h0)) begin
            errors++;
            $display("FAIL stall_perf got %0d/%0d exp %0d/%0d", perf_f, perf_s, PERF ? 6 : 0, PERF ? 2 : 0);
        end
    endtask

    task automatic test_pc_wrap();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({imem_if.imem_req_87, instr_vld, instr_out, pc_out} !== 66'h0) begin
            errors++;
            $display("FAIL midop_reset got req=%b vld=%b instr=%h pc=%h exp all 0",
                     imem_if.imem_req_87, instr_vld, instr_out, pc_out);
        end
        repeat (4) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({wrap_if.imem_req_87, wrap_if.imem_addr_87} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_first got req=%b addr=%h exp 1/fffffffc", wrap_if.imem_req_87, wrap_if.imem_addr_87);
        end
        tick();
        checks++;
        if ({wrap_if.imem_req_87, wrap_if.imem_addr_87} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_second got req=%b addr=%h exp 1/00000000", wrap_if.imem_req_87, wrap_if.imem_addr_87);
        end
        tick();
        checks++;
        if ({wrap_if.imem_req_87, wrap_if.imem_addr_87} !== {1'b0, 32'h4}) begin
            errors++;
            $display("FAIL wrap_credit got req=%b addr=%h exp 0/00000004", wrap_if.imem_req_87, wrap_if.imem_addr_87);
        end
    endtask

    task automatic test_redirect();
        rst = 1'b1;
        lat = 3;
        repeat (6) tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (imem_if.imem_req_87 !== 1'b0) begin
            errors++;
            $display("FAIL redir_inflight got req=%b exp 0", imem_if.imem_req_87);
        end
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        checks++;
        if ({imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld, instr_out} !== {1'b0, 32'h100, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL redir_take got req=%b addr=%h vld=%b instr=%h exp 0/00000100/0/0",
                     imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld, instr_out);
        end
        tick();
        checks++;
        if ({imem_if.imem_req_87, instr_vld} !== 2'b00) begin
            errors++;
            $display("FAIL redir_flush got req=%b vld=%b exp 0/0", imem_if.imem_req_87, instr_vld);
        end
        tick();
        checks++;
        if ({imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL redir_refetch got req=%b addr=%h vld=%b exp 1/00000100/0",
                     imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (instr_vld !== 1'b0) begin
                errors++;
                $display("FAIL redir_stale_%0d got vld=%b instr=%h exp vld 0", k, instr_vld, instr_out);
            end
        end
        checks++;
        if (perf_s !== (PERF ? 32'd9 : 32'd0)) begin
            errors++;
            $display("FAIL redir_bubbles got %0d exp %0d", perf_s, PERF ? 9 : 0);
        end
        tick();
        checks++;
        if ({instr_vld, instr_out, pc_out} !== {1'b1, 32'h100, 32'h104}) begin
            errors++;
            $display("FAIL redir_first got vld=%b instr=%h pc=%h exp 1/00000100/00000104", instr_vld, instr_out, pc_out);
        end
        tick();
        checks++;
        if ({instr_vld, instr_out, pc_out} !== {1'b1, 32'h104, 32'h108}) begin
            errors++;
            $display("FAIL redir_second got vld=%b instr=%h pc=%h exp 1/00000104/00000108", instr_vld, instr_out, pc_out);
        end
    endtask

    task automatic test_rsp_redirect();
        rst = 1'b1;
        lat = 1;
        repeat (6) tick();
        rst = 1'b0;
        repeat (2) tick();
        imem_if.imem_rdy_87 = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h203;
        tick();
        imem_if.imem_rdy_87 = 1'b1;
        redirect = 1'b0;
        checks++;
        if ({imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld, instr_out} !== {1'b0, 32'h200, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL coll_take got req=%b addr=%h vld=%b instr=%h exp 0/00000200/0/0",
                     imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld, instr_out);
        end
        tick();
        checks++;
        if ({imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld} !== {1'b1, 32'h200, 1'b0}) begin
            errors++;
            $display("FAIL coll_refetch got req=%b addr=%h vld=%b exp 1/00000200/0",
                     imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld);
        end
        tick();
        checks++;
        if (instr_vld !== 1'b0) begin
            errors++;
            $display("FAIL coll_dropped got vld=%b instr=%h exp vld 0", instr_vld, instr_out);
        end
        checks++;
        if (perf_s !== (PERF ? 32'd5 : 32'd0)) begin
            errors++;
            $display("FAIL coll_bubbles got %0d exp %0d", perf_s, PERF ? 5 : 0);
        end
        tick();
        checks++;
        if ({instr_vld, instr_out, pc_out} !== {1'b1, 32'h200, 32'h204}) begin
            errors++;
            $display("FAIL coll_first got vld=%b instr=%h pc=%h exp 1/00000200/00000204", instr_vld, instr_out, pc_out);
        end
        tick();
        checks++;
        if ({instr_vld, instr_out, pc_out} !== {1'b1, 32'h204, 32'h208}) begin
            errors++;
            $display("FAIL coll_second got vld=%b instr=%h pc=%h exp 1/00000204/00000208", instr_vld, instr_out, pc_out);
        end
    endtask

    task automatic test_rdy_low();
        imem_if.imem_rdy_87 = 1'b0;
        tick();
        checks++;
        if ({instr_vld, instr_out, pc_out} !== {1'b1, 32'h208, 32'h20C}) begin
            errors++;
            $display("FAIL rdy_inflight got vld=%b instr=%h pc=%h exp 1/00000208/0000020c", instr_vld, instr_out, pc_out);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld, instr_out} !== {1'b1, 32'h20C, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL rdy_hold_%0d got req=%b addr=%h vld=%b instr=%h exp 1/0000020c/0/0",
                         k, imem_if.imem_req_87, imem_if.imem_addr_87, instr_vld, instr_out);
            end
        end
        imem_if.imem_rdy_87 = 1'b1;
        tick();
        checks++;
        if (instr_vld !== 1'b0) begin
            errors++;
            $display("FAIL rdy_wait got vld=%b exp 0", instr_vld);
        end
        checks++;
        if (perf_s !== (PERF ? 32'd10 : 32'd0)) begin
            errors++;
            $display("FAIL rdy_bubbles got %0d exp %0d", perf_s, PERF ? 10 : 0);
        end
        tick();
        checks++;
        if ({instr_vld, instr_out, pc_out} !== {1'b1, 32'h20C, 32'h210}) begin
            errors++;
            $display("FAIL rdy_resume got vld=%b instr=%h pc=%h exp 1/0000020c/00000210", instr_vld, instr_out, pc_out);
        end
        checks++;
        if (perf_f !== (PERF ? 32'd4 : 32'd0)) begin
            errors++;
            $display("FAIL rdy_fetched got %0d exp %0d", perf_f, PERF ? 4 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_pc_wrap();
        test_redirect();
        test_rsp_redirect();
        test_rdy_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
